// File: rtl/master_port.sv
// master_port: master-side serial endpoint for the single-wire request link.
//
// Takes one read or write command from a parallel host handshake and serialises
// it towards a slave endpoint. A frame is: start (line low), wait for the slave
// ack on rx, three align cycles, the address LSB-first, one mode bit
// (1 = write), then either the write data LSB-first or a turnaround followed by
// sampling the read data from rx. Completion or an ack timeout is reported with
// a one-cycle resp_valid. The port then holds the line high for two cycles
// before it accepts the next command.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   req_valid / req_ready      host command handshake
//   req_write                  1 = write, 0 = read
//   req_addr, req_wdata        command address and write data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata                 read data, held until the next read completion
//   resp_err                   ack timeout, qualified by resp_valid
//   tx                         serial line to slave rx, idle high
//   rx                         serial line from slave tx, idle high, low = ack
module master_port #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              tx,
  input  logic              rx
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  // Bit-counter thresholds, one per state that counts.
  localparam logic [4:0]        ALIGN_LAST = 5'd2;
  localparam logic [4:0]        ADDR_LAST  = 5'(ADDR_W - 1);
  localparam logic [4:0]        WR_STOP    = 5'(DATA_W);
  localparam logic [4:0]        WR_RESP    = 5'(DATA_W + 1);
  localparam logic [4:0]        RD_FIRST   = 5'd2;
  localparam logic [4:0]        RD_RESP    = 5'(DATA_W + 2);
  localparam logic [4:0]        GAP_LAST   = 5'd1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_ACK, ALIGN, ADDR, WDATA, RDATA, GAP
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
  // Shared data shifter: write data leaves from bit 0, read data enters at the
  // MSB, so after DATA_W shifts either direction ends up LSB-first.
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic                tx_d, req_ready_d, resp_valid_d, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_d;

  // rx comes from a slave clocked by clk, so it is sampled directly.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    write_d      = write_q;
    addr_sh_d    = addr_sh_q;
    data_sh_d    = data_sh_q;
    tx_d         = tx;
    req_ready_d  = req_ready;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d     = req_write;
          addr_sh_d   = req_addr;
          data_sh_d   = req_wdata;
          tx_d        = 1'b0;
          req_ready_d = 1'b0;
          wait_cnt_d  = '0;
          bit_cnt_d   = '0;
          state_d     = WAIT_ACK;
        end
      end

      // The line stays low for as long as the slave stalls; an ack on the
      // same edge as the timeout is taken as an ack.
      WAIT_ACK: begin
        if (!rx) begin
          bit_cnt_d = '0;
          state_d   = ALIGN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          tx_d         = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          bit_cnt_d    = '0;
          state_d      = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // Address bit 0 goes out on the edge that leaves ALIGN.
      ALIGN: begin
        if (bit_cnt_q == ALIGN_LAST) begin
          tx_d      = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
          bit_cnt_d = '0;
          state_d   = ADDR;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      // bit_cnt counts address bits already on the line after bit 0.
      ADDR: begin
        if (bit_cnt_q == ADDR_LAST) begin
          tx_d      = write_q;
          bit_cnt_d = '0;
          state_d   = write_q ? WDATA : RDATA;
        end else begin
          tx_d      = addr_sh_q[0];
          addr_sh_d = addr_sh_q >> 1;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      WDATA: begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q < WR_STOP) begin
          tx_d      = data_sh_q[0];
          data_sh_d = data_sh_q >> 1;
        end else if (bit_cnt_q == WR_STOP) begin
          tx_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          bit_cnt_d    = '0;
          state_d      = GAP;
        end
      end

      // Release the line, skip one turnaround cycle, then sample DATA_W bits.
      RDATA: begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == '0) begin
          tx_d = 1'b1;
        end else if (bit_cnt_q >= RD_FIRST && bit_cnt_q < RD_RESP) begin
          data_sh_d = {rx, data_sh_q[DATA_W-1:1]};
        end else if (bit_cnt_q == RD_RESP) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = data_sh_q;
          bit_cnt_d    = '0;
          state_d      = GAP;
        end
      end

      // Two high cycles so the slave is back in idle before the next start.
      GAP: begin
        if (bit_cnt_q == GAP_LAST) begin
          req_ready_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      default: begin
        tx_d        = 1'b1;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      tx         <= 1'b1;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      tx         <= tx_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port. Two instances share the stimulus: dut uses the
// default ack timeout, dut_to uses ACK_TIMEOUT=10. 'sel' routes the host
// handshake and the slave line to one of them. The slave is modelled by
// timing alone: it acks 'busy' cycles late, returns read data on the sampled
// edges, and puts random noise on rx wherever the port must ignore it.
module tb_master_port;
  localparam int ACK_TO = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rx = 1'b1;
  logic        sel = 1'b0;

  logic        req_ready_a, resp_valid_a, resp_err_a, tx_a;
  logic [7:0]  resp_rdata_a;
  logic        req_ready_t, resp_valid_t, resp_err_t, tx_t;
  logic [7:0]  resp_rdata_t;
  logic        req_ready_m, resp_valid_m, resp_err_m, tx_m;
  logic [7:0]  resp_rdata_m;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_r = -100;
  logic [7:0]  model_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  master_port dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .tx(tx_a), .rx(sel ? 1'b1 : rx)
  );

  master_port #(.ACK_TIMEOUT(ACK_TO)) dut_to (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid & sel), .req_ready(req_ready_t),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
    .tx(tx_t), .rx(sel ? rx : 1'b1)
  );

  assign req_ready_m  = sel ? req_ready_t  : req_ready_a;
  assign resp_valid_m = sel ? resp_valid_t : resp_valid_a;
  assign resp_err_m   = sel ? resp_err_t   : resp_err_a;
  assign resp_rdata_m = sel ? resp_rdata_t : resp_rdata_a;
  assign tx_m         = sel ? tx_t         : tx_a;

  // Line level expected after edge D+t of a frame.
  function automatic logic exp_line(int t, logic w, logic [11:0] a, logic [7:0] wd);
    if (t < 3)  return 1'b0;
    if (t < 15) return a[t-3];
    if (t == 15) return w;
    if (w && t < 24) return wd[t-16];
    return 1'b1;
  endfunction

  // Issue one command and follow it cycle by cycle to the end of its gap.
  // busy < 0 means the slave never acks. abort_t >= 0 pulses rstn at D+abort_t.
  task automatic run_cmd(input logic w, input logic [11:0] a, input logic [7:0] wd,
                         input int busy, input logic [7:0] rd, input bit hold,
                         input bit b2b, input int abort_t,
                         output logic [11:0] cap_a, output logic [7:0] cap_d);
    int s, d, rl, t, n, off;
    bit rdy, done;
    logic etx, ev, erdy;
    cap_a = '0;
    cap_d = '0;
    req_write = w; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    s = -1; n = 0;
    while (s < 0 && n < 50) begin
      rdy = req_ready_m;
      @(posedge clk); #1;
      n++;
      if (rdy) s = cyc;
    end
    checks++;
    if (s < 0) begin
      errors++;
      $display("FAIL accept: no accept within 50 cycles, required accept");
      req_valid = 1'b0;
      return;
    end
    if (b2b) begin
      checks++;
      if (s != last_r + 3) begin
        errors++;
        $display("FAIL b2b_accept: accept %0d cycles after resp, required 3", s - last_r);
      end
    end
    if (!hold) req_valid = 1'b0;
    // The port must work from its latched copy of the command.
    req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = 8'($urandom);
    d = (busy < 0) ? -1 : s + 3 + busy;
    rl = w ? 25 : 26;
    done = 1'b0;
    while (!done) begin
      off = cyc - s;
      if (busy < 0) begin
        etx = (off >= ACK_TO); ev = (off == ACK_TO); erdy = (off >= ACK_TO + 2);
        done = (off >= ACK_TO + 2);
      end else if (cyc < d) begin
        etx = 1'b0; ev = 1'b0; erdy = 1'b0;
      end else begin
        t = cyc - d;
        etx = exp_line(t, w, a, wd); ev = (t == rl); erdy = (t >= rl + 2);
        done = (t >= rl + 2);
        if (t >= 3 && t < 15) cap_a[t-3] = tx_m;
        if (w && t >= 16 && t < 24) cap_d[t-16] = tx_m;
      end
      checks++;
      if (tx_m !== etx) begin
        errors++; $display("FAIL tx: cycle S+%0d got %b required %b", off, tx_m, etx);
      end
      checks++;
      if (resp_valid_m !== ev) begin
        errors++; $display("FAIL resp_valid: cycle S+%0d got %b required %b", off, resp_valid_m, ev);
      end
      checks++;
      if (req_ready_m !== erdy) begin
        errors++; $display("FAIL req_ready: cycle S+%0d got %b required %b", off, req_ready_m, erdy);
      end
      if (ev) begin
        checks++;
        if (resp_err_m !== (busy < 0)) begin
          errors++; $display("FAIL resp_err: got %b required %b", resp_err_m, busy < 0);
        end
        if (!w && busy >= 0) model_rd[sel] = rd;
      end
      checks++;
      if (resp_rdata_m !== model_rd[sel]) begin
        errors++; $display("FAIL resp_rdata: cycle S+%0d got %h required %h", off, resp_rdata_m, model_rd[sel]);
      end
      if (abort_t >= 0 && d >= 0 && cyc == d + abort_t) begin
        rstn = 1'b0;
        #1;
        model_rd[0] = '0; model_rd[1] = '0;
        checks++;
        if (tx_m !== 1'b1 || req_ready_m !== 1'b1 || resp_valid_m !== 1'b0 || resp_rdata_m !== 8'h00) begin
          errors++;
          $display("FAIL async_reset: tx=%b ready=%b valid=%b rdata=%h required 1 1 0 00",
                   tx_m, req_ready_m, resp_valid_m, resp_rdata_m);
        end
        rx = 1'b1; req_valid = 1'b0;
        #2 rstn = 1'b1;
        repeat (4) begin
          @(posedge clk); #1;
          checks++;
          if (resp_valid_m !== 1'b0 || tx_m !== 1'b1 || req_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b tx=%b ready=%b required 0 1 1",
                     resp_valid_m, tx_m, req_ready_m);
          end
        end
        return;
      end
      if (!done) begin
        if (busy >= 0 && cyc == s + 2 + busy) rx = 1'b0;
        else if (d >= 0 && cyc >= d) begin
          t = cyc - d;
          if (!w && t >= 17 && t <= 24) rx = rd[t-17];
          else if (t <= rl) rx = 1'($urandom);
          else rx = 1'b1;
        end else rx = 1'b1;
        @(posedge clk); #1;
      end
    end
    rx = 1'b1;
    last_r = (busy < 0) ? s + ACK_TO : d + rl;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++;
    if (tx_a !== 1'b1 || req_ready_a !== 1'b1 || resp_valid_a !== 1'b0 ||
        resp_err_a !== 1'b0 || resp_rdata_a !== 8'h00 ||
        tx_t !== 1'b1 || req_ready_t !== 1'b1 || resp_valid_t !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b ready=%b valid=%b err=%b rdata=%h required 1 1 0 0 00",
               tx_a, req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a);
    end
    model_rd[0] = '0; model_rd[1] = '0;
    #2 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b0;
    run_cmd(1'b1, 12'hABC, 8'h5A, 0, 8'h00, 1'b0, 1'b0, -1, ca, cd);
    checks++;
    if (ca !== 12'hABC || cd !== 8'h5A) begin
      errors++; $display("FAIL write_capture: addr=%h data=%h required abc 5a", ca, cd);
    end
  endtask

  task automatic test_read();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b0;
    run_cmd(1'b0, 12'h001, 8'h00, 0, 8'hD3, 1'b0, 1'b0, -1, ca, cd);
    checks++;
    if (ca !== 12'h001 || resp_rdata_m !== 8'hD3) begin
      errors++; $display("FAIL read: addr=%h rdata=%h required 001 d3", ca, resp_rdata_m);
    end
  endtask

  task automatic test_busy();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b0;
    run_cmd(1'b1, 12'h3C5, 8'hA7, 20, 8'h00, 1'b0, 1'b0, -1, ca, cd);
    checks++;
    if (ca !== 12'h3C5 || cd !== 8'hA7) begin
      errors++; $display("FAIL busy_capture: addr=%h data=%h required 3c5 a7", ca, cd);
    end
  endtask

  // No ack at all, then acks one and zero cycles before the timeout edge.
  task automatic test_timeout();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b1;
    run_cmd(1'b1, 12'h555, 8'h11, -1, 8'h00, 1'b0, 1'b0, -1, ca, cd);
    run_cmd(1'b0, 12'h0F0, 8'h00, ACK_TO - 4, 8'h6B, 1'b0, 1'b0, -1, ca, cd);
    run_cmd(1'b1, 12'h70E, 8'hC4, ACK_TO - 3, 8'h00, 1'b0, 1'b0, -1, ca, cd);
    checks++;
    if (ca !== 12'h70E || cd !== 8'hC4) begin
      errors++; $display("FAIL ack_wins_capture: addr=%h data=%h required 70e c4", ca, cd);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b0;
    run_cmd(1'b1, 12'h9A2, 8'h3E, 1, 8'h00, 1'b1, 1'b0, -1, ca, cd);
    run_cmd(1'b0, 12'h001, 8'h00, 0, 8'hD3, 1'b0, 1'b1, -1, ca, cd);
    checks++;
    if (resp_rdata_m !== 8'hD3) begin
      errors++; $display("FAIL b2b_read: rdata=%h required d3", resp_rdata_m);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] ca; logic [7:0] cd;
    sel = 1'b0;
    run_cmd(1'b1, 12'hFFF, 8'hFF, 0, 8'h00, 1'b0, 1'b0, 8, ca, cd);
    run_cmd(1'b1, 12'h246, 8'h81, 0, 8'h00, 1'b0, 1'b0, -1, ca, cd);
    checks++;
    if (ca !== 12'h246 || cd !== 8'h81) begin
      errors++; $display("FAIL after_reset_capture: addr=%h data=%h required 246 81", ca, cd);
    end
  endtask

  task automatic test_random();
    logic [11:0] ca, a; logic [7:0] cd, wd, rd; logic w;
    for (int i = 0; i < 16; i++) begin
      sel = (i % 4 == 3);
      w = 1'($urandom); a = 12'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      run_cmd(w, a, wd, int'($urandom_range(0, 6)), rd, 1'b0, 1'b0, -1, ca, cd);
      checks++;
      if (ca !== a || (w && cd !== wd)) begin
        errors++; $display("FAIL random_capture %0d: addr=%h data=%h required %h %h", i, ca, cd, a, wd);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
